// File: rtl/key_events.sv
// Per-key debounce and event generator: turns raw active-low key pins into a
// debounced level plus single-cycle press, release, long-press and repeat pulses.
module key_events #(
    parameter int unsigned KEYS            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [KEYS-1:0] key_n,
    output logic [KEYS-1:0] key_state,
    output logic [KEYS-1:0] key_down,
    output logic [KEYS-1:0] key_up,
    output logic [KEYS-1:0] key_long,
    output logic [KEYS-1:0] key_rpt
);

    localparam int unsigned MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        DOWN,
        HELD,
        REL_WAIT
    } state_t;

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        logic          sync1;
        logic          sync2;
        state_t        state;
        logic          from_held;
        logic [CW-1:0] deb_cnt;
        logic [CW-1:0] hold_cnt;
        logic          state_r;
        logic          down_r;
        logic          up_r;
        logic          long_r;
        logic          rpt_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1     <= 1'b1;
                sync2     <= 1'b1;
                state     <= IDLE;
                from_held <= 1'b0;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                state_r   <= 1'b0;
                down_r    <= 1'b0;
                up_r      <= 1'b0;
                long_r    <= 1'b0;
                rpt_r     <= 1'b0;
            end else begin
                sync1  <= key_n[k];
                sync2  <= sync1;
                down_r <= 1'b0;
                up_r   <= 1'b0;
                long_r <= 1'b0;
                rpt_r  <= 1'b0;

                case (state)
                    IDLE: begin
                        if (!sync2) begin
                            state   <= PRESS_WAIT;
                            deb_cnt <= '0;
                        end
                    end

                    PRESS_WAIT: begin
                        if (sync2) begin
                            state <= IDLE;
                        end else if (deb_cnt == DEB_LAST) begin
                            state    <= DOWN;
                            down_r   <= 1'b1;
                            state_r  <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end

                    // A release sample takes priority over a coinciding hold/repeat expiry.
                    DOWN: begin
                        if (sync2) begin
                            state     <= REL_WAIT;
                            from_held <= 1'b0;
                            deb_cnt   <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state    <= HELD;
                            long_r   <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end

                    HELD: begin
                        if (sync2) begin
                            state     <= REL_WAIT;
                            from_held <= 1'b1;
                            deb_cnt   <= '0;
                        end else if (hold_cnt == RPT_LAST) begin
                            rpt_r    <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end

                    // hold_cnt is left untouched here so the hold/repeat timing resumes on a bounce.
                    REL_WAIT: begin
                        if (!sync2) begin
                            state <= from_held ? HELD : DOWN;
                        end else if (deb_cnt == DEB_LAST) begin
                            state   <= IDLE;
                            up_r    <= 1'b1;
                            state_r <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end

        assign key_state[k] = state_r;
        assign key_down[k]  = down_r;
        assign key_up[k]    = up_r;
        assign key_long[k]  = long_r;
        assign key_rpt[k]   = rpt_r;
    end

endmodule

// File: tb/tb_key_events.sv
// Bench for key_events: directed scenarios with literal event timing plus
// randomized key activity checked every cycle against a run-length model.
module tb_key_events;

    localparam int unsigned NK  = 2;
    localparam int          DEB = 4;
    localparam int          HLD = 20;
    localparam int          RPT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_state, key_down, key_up, key_long, key_rpt;

    key_events #(
        .KEYS(NK),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HLD),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_n(key_n),
        .key_state(key_state),
        .key_down(key_down),
        .key_up(key_up),
        .key_long(key_long),
        .key_rpt(key_rpt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edge_no = 0;
    bit chk_en = 0;
    bit cap = 0;
    int t0 = 0;
    int ev[$];
    int exq[$];
    int st_cnt = 0;
    int st_first = -1;

    // Behavioural model: the synchronizer is a two-sample delay of the raw pin;
    // a level flips after DEB+1 consecutive disagreeing samples; hold time
    // accumulates only over pressed samples that are not part of a pending release.
    logic [NK-1:0] d1 = '1, d2 = '1;
    int  run[NK];
    bit  pressed[NK];
    int  hold_t[NK];
    bit  long_done[NK];
    logic [NK-1:0] m_state = '0, m_down = '0, m_up = '0, m_long = '0, m_rpt = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1 = '1; d2 = '1;
            m_state = '0; m_down = '0; m_up = '0; m_long = '0; m_rpt = '0;
            for (int k = 0; k < NK; k++) begin
                run[k] = 0; pressed[k] = 0; hold_t[k] = 0; long_done[k] = 0;
            end
        end else begin
            m_down = '0; m_up = '0; m_long = '0; m_rpt = '0;
            for (int k = 0; k < NK; k++) begin
                if (!pressed[k]) begin
                    if (!d2[k]) begin
                        run[k]++;
                        if (run[k] == DEB + 1) begin
                            pressed[k] = 1; run[k] = 0; hold_t[k] = 0; long_done[k] = 0;
                            m_down[k] = 1'b1; m_state[k] = 1'b1;
                        end
                    end else begin
                        run[k] = 0;
                    end
                end else begin
                    if (d2[k]) begin
                        run[k]++;
                        if (run[k] == DEB + 1) begin
                            pressed[k] = 0; run[k] = 0;
                            m_up[k] = 1'b1; m_state[k] = 1'b0;
                        end
                    end else if (run[k] > 0) begin
                        run[k] = 0;
                    end else begin
                        hold_t[k]++;
                        if (!long_done[k] && hold_t[k] == HLD) begin
                            m_long[k] = 1'b1; long_done[k] = 1; hold_t[k] = 0;
                        end else if (long_done[k] && hold_t[k] == RPT) begin
                            m_rpt[k] = 1'b1; hold_t[k] = 0;
                        end
                    end
                end
            end
            d2 = d1;
            d1 = key_n;
        end
    end

    always @(posedge clk) edge_no++;

    function automatic int enc(input int t, input int k, input int rel);
        return t * 10000 + k * 1000 + rel;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({key_state, key_down, key_up, key_long, key_rpt} !==
                {m_state, m_down, m_up, m_long, m_rpt}) begin
                bad++;
                $display("FAIL model_cmp edge=%0d got st=%b dn=%b up=%b lg=%b rp=%b want st=%b dn=%b up=%b lg=%b rp=%b",
                         edge_no, key_state, key_down, key_up, key_long, key_rpt,
                         m_state, m_down, m_up, m_long, m_rpt);
            end
            if (cap) begin
                for (int t = 0; t < 4; t++) begin
                    for (int k = 0; k < NK; k++) begin
                        logic [NK-1:0] pv;
                        case (t)
                            0: pv = key_down;
                            1: pv = key_up;
                            2: pv = key_long;
                            default: pv = key_rpt;
                        endcase
                        if (pv[k]) ev.push_back(enc(t, k, edge_no - t0));
                    end
                end
                if (key_state[0]) begin
                    if (st_first < 0) st_first = edge_no - t0;
                    st_cnt++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ex(input int t, input int k, input int rel);
        exq.push_back(enc(t, k, rel));
    endtask

    task automatic check_ev(input string name);
        chk({name, "_count"}, ev.size(), exq.size());
        for (int i = 0; i < exq.size() && i < ev.size(); i++)
            chk($sformatf("%s_ev%0d", name, i), ev[i], exq[i]);
        exq.delete();
    endtask

    task automatic drive(input logic [NK-1:0] kn, input int n);
        repeat (n) begin
            @(negedge clk);
            key_n = kn;
        end
    endtask

    // The value driven here is sampled by relative edge 0.
    task automatic begin_scn(input logic [NK-1:0] kn);
        @(negedge clk);
        key_n = kn;
        t0 = edge_no + 1;
        ev.delete();
        st_cnt = 0;
        st_first = -1;
        cap = 1;
    endtask

    int unsigned remain[NK];
    logic [NK-1:0] lvl;

    initial begin
        #3 reset_n = 1'b0;
        #1;
        chk("reset_state", int'(key_state), 0);
        chk("reset_pulses", int'({key_down, key_up, key_long, key_rpt}), 0);
        #16;
        chk_en = 1;
        @(negedge clk);
        reset_n = 1'b1;
        drive('1, 5);

        // Clean press/release on key 0.
        begin_scn(2'b10);
        drive(2'b10, 11);
        drive(2'b11, 30);
        ex(0, 0, 6); ex(1, 0, 18);
        check_ev("clean");
        chk("clean_state_first", st_first, 6);
        chk("clean_state_cycles", st_cnt, 12);

        // Short glitch, then sustained bounce.
        begin_scn(2'b10);
        drive(2'b10, 2);
        drive(2'b11, 20);
        check_ev("glitch3");
        chk("glitch3_state", st_cnt, 0);
        begin_scn(2'b10);
        drive(2'b10, 1);
        for (int i = 0; i < 9; i++) begin
            drive(2'b11, 2);
            drive(2'b10, 2);
        end
        drive(2'b11, 20);
        check_ev("bounce40");
        chk("bounce40_state", st_cnt, 0);

        // Long hold with auto-repeat.
        begin_scn(2'b10);
        drive(2'b10, 44);
        drive(2'b11, 30);
        ex(0, 0, 6); ex(2, 0, 26); ex(3, 0, 34); ex(3, 0, 42); ex(1, 0, 51);
        check_ev("long_hold");

        // Release bounce after long: hold count is frozen, not cleared.
        begin_scn(2'b10);
        drive(2'b10, 29);
        drive(2'b11, 2);
        drive(2'b10, 8);
        drive(2'b11, 30);
        ex(0, 0, 6); ex(2, 0, 26); ex(3, 0, 37); ex(1, 0, 46);
        check_ev("rel_bounce");

        // Reset while HELD and still pressed.
        begin_scn(2'b10);
        drive(2'b10, 34);
        @(negedge clk);
        chk("pre_reset_state", int'(key_state[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_state", int'(key_state), 0);
        chk("async_reset_pulses", int'({key_down, key_up, key_long, key_rpt}), 0);
        ev.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        t0 = edge_no + 1;
        ev.delete();
        drive(2'b10, 30);
        drive(2'b11, 30);
        ex(0, 0, 6); ex(2, 0, 26); ex(1, 0, 37);
        check_ev("reset_hold");

        // Two keys, simultaneous press.
        begin_scn(2'b00);
        drive(2'b00, 9);
        drive(2'b10, 4);
        drive(2'b11, 30);
        ex(0, 0, 6); ex(0, 1, 6); ex(1, 1, 16); ex(1, 0, 20);
        check_ev("two_keys");
        cap = 0;

        // Randomized activity on both keys, with one async reset in the middle.
        lvl = '1;
        for (int k = 0; k < NK; k++) remain[k] = 0;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) begin
                if (remain[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    remain[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(5, 60);
                end else begin
                    remain[k]--;
                end
            end
            key_n = lvl;
            if (it == 2000) begin
                #2 reset_n = 1'b0;
                #4 reset_n = 1'b1;
            end
        end
        drive('1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
